// File: rtl/mat_vec_mul_arb_if.sv
// mat_vec_mul_arb_if: requester and engine signals of the shared mat_vec_mul arbiter.
interface mat_vec_mul_arb_if #(
    parameter int N_REQ      = 2,
    parameter int PROC_SIZE  = 16,
    parameter int MAT_ADDR_W = 5,
    parameter int VEC_ADDR_W = 3
);
    logic [N_REQ-1:0]           i_req;
    logic [N_REQ-1:0]           o_gnt;
    logic [N_REQ-1:0]           o_done;
    logic [N_REQ-1:0]           o_err;
    logic [N_REQ*PROC_SIZE-1:0] i_mat_flat;
    logic [N_REQ*PROC_SIZE-1:0] i_vec_flat;
    logic [MAT_ADDR_W-1:0]      o_mat_addr;
    logic [VEC_ADDR_W:0]        o_vec_addr;
    logic                       o_eng_start;
    logic [MAT_ADDR_W-1:0]      i_eng_mat_addr;
    logic [VEC_ADDR_W:0]        i_eng_vec_addr;
    logic [PROC_SIZE-1:0]       o_eng_mat;
    logic [PROC_SIZE-1:0]       o_eng_vec;
    logic                       i_eng_done;

    modport slave (
        input  i_req, i_mat_flat, i_vec_flat, i_eng_mat_addr, i_eng_vec_addr, i_eng_done,
        output o_gnt, o_done, o_err, o_mat_addr, o_vec_addr, o_eng_start, o_eng_mat, o_eng_vec
    );

    modport master (
        output i_req, i_mat_flat, i_vec_flat, i_eng_mat_addr, i_eng_vec_addr, i_eng_done,
        input  o_gnt, o_done, o_err, o_mat_addr, o_vec_addr, o_eng_start, o_eng_mat, o_eng_vec
    );
endinterface

// File: rtl/mat_vec_mul_arb.sv
// mat_vec_mul_arb: round-robin arbiter/sequencer sharing one mat_vec_mul engine among N_REQ requesters.
module mat_vec_mul_arb #(
    parameter int N_REQ      = 2,
    parameter int PROC_SIZE  = 16,
    parameter int MAT_ADDR_W = 5,
    parameter int VEC_ADDR_W = 3,
    parameter int TIMEOUT    = 1024
) (
    input logic             i_clk,
    input logic             i_rst_n,
    mat_vec_mul_arb_if.slave bus
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, START, RUN, HOLD} state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [N_REQ-1:0] err_q, err_d;
    logic             start_q, start_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic [IDX_W-1:0] win;
    logic             found;

    // First pending request strictly after last, wrapping modulo N_REQ.
    always_comb begin
        win   = last_q;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!found && bus.i_req[(int'(last_q) + i) % N_REQ]) begin
                win   = IDX_W'((int'(last_q) + i) % N_REQ);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        done_d  = '0;
        err_d   = '0;
        case (state_q)
            IDLE: if (found) begin
                state_d = START;
                gnt_d   = N_REQ'(1) << win;
                sel_d   = win;
                start_d = 1'b1;
                cnt_d   = '0;
            end
            START: state_d = RUN;
            RUN: begin
                if (bus.i_eng_done) begin
                    state_d = HOLD;
                    done_d  = gnt_q;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = HOLD;
                    err_d   = gnt_q;
                end else begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                end
            end
            HOLD: if (!bus.i_req[sel_q]) begin
                state_d = IDLE;
                gnt_d   = '0;
                last_d  = sel_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            start_q <= 1'b0;
            cnt_q   <= '0;
            last_q  <= IDX_W'(N_REQ - 1);
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            start_q <= start_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
        end
    end

    assign bus.o_gnt       = gnt_q;
    assign bus.o_done      = done_q;
    assign bus.o_err       = err_q;
    assign bus.o_eng_start = start_q;
    assign bus.o_mat_addr  = bus.i_eng_mat_addr;
    assign bus.o_vec_addr  = bus.i_eng_vec_addr;
    assign bus.o_eng_mat   = (|gnt_q) ? bus.i_mat_flat[sel_q*PROC_SIZE +: PROC_SIZE] : '0;
    assign bus.o_eng_vec   = (|gnt_q) ? bus.i_vec_flat[sel_q*PROC_SIZE +: PROC_SIZE] : '0;
endmodule

// File: tb/tb_mat_vec_mul_arb.sv
// tb_mat_vec_mul_arb: cycle-table and directed timeout checks for mat_vec_mul_arb.
module tb_mat_vec_mul_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mat_vec_mul_arb_if #(.N_REQ(2), .PROC_SIZE(16), .MAT_ADDR_W(5), .VEC_ADDR_W(3)) bus ();

    mat_vec_mul_arb #(
        .N_REQ(2), .PROC_SIZE(16), .MAT_ADDR_W(5), .VEC_ADDR_W(3), .TIMEOUT(16)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic        rst_n;
        logic [1:0]  req;
        logic        eng_done;
        logic [4:0]  addr;
        logic [1:0]  gnt;
        logic [1:0]  done;
        logic [1:0]  err;
        logic        start;
        logic [15:0] mat;
    } vec_t;

    vec_t tbl[26];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    initial begin
        logic [15:0] exp_vec;
        bus.i_req          = '0;
        bus.i_eng_done     = 1'b0;
        bus.i_mat_flat     = 32'h3C3C_A5A5;
        bus.i_vec_flat     = 32'h1111_2222;
        bus.i_eng_mat_addr = '0;
        bus.i_eng_vec_addr = '0;
        //          rst req dn addr   gnt    done   err   st  mat
        tbl[0]  = '{0, 2'b00, 0, 5'd0,  2'b00, 2'b00, 2'b00, 0, 16'h0000};
        tbl[1]  = '{1, 2'b01, 0, 5'd1,  2'b01, 2'b00, 2'b00, 1, 16'hA5A5};
        tbl[2]  = '{1, 2'b01, 0, 5'd2,  2'b01, 2'b00, 2'b00, 0, 16'hA5A5};
        tbl[3]  = '{1, 2'b01, 1, 5'd3,  2'b01, 2'b01, 2'b00, 0, 16'hA5A5};
        tbl[4]  = '{1, 2'b01, 0, 5'd4,  2'b01, 2'b00, 2'b00, 0, 16'hA5A5};
        tbl[5]  = '{1, 2'b00, 0, 5'd5,  2'b00, 2'b00, 2'b00, 0, 16'h0000};
        tbl[6]  = '{1, 2'b11, 0, 5'd6,  2'b10, 2'b00, 2'b00, 1, 16'h3C3C};
        tbl[7]  = '{1, 2'b11, 0, 5'd7,  2'b10, 2'b00, 2'b00, 0, 16'h3C3C};
        tbl[8]  = '{1, 2'b11, 1, 5'd8,  2'b10, 2'b10, 2'b00, 0, 16'h3C3C};
        tbl[9]  = '{1, 2'b01, 0, 5'd9,  2'b00, 2'b00, 2'b00, 0, 16'h0000};
        tbl[10] = '{1, 2'b11, 0, 5'd10, 2'b01, 2'b00, 2'b00, 1, 16'hA5A5};
        tbl[11] = '{1, 2'b11, 0, 5'd11, 2'b01, 2'b00, 2'b00, 0, 16'hA5A5};
        tbl[12] = '{1, 2'b11, 1, 5'd12, 2'b01, 2'b01, 2'b00, 0, 16'hA5A5};
        tbl[13] = '{1, 2'b10, 0, 5'd13, 2'b00, 2'b00, 2'b00, 0, 16'h0000};
        tbl[14] = '{1, 2'b11, 0, 5'd14, 2'b10, 2'b00, 2'b00, 1, 16'h3C3C};
        tbl[15] = '{1, 2'b00, 0, 5'd15, 2'b10, 2'b00, 2'b00, 0, 16'h3C3C};
        tbl[16] = '{1, 2'b00, 1, 5'd16, 2'b10, 2'b10, 2'b00, 0, 16'h3C3C};
        tbl[17] = '{1, 2'b00, 0, 5'd17, 2'b00, 2'b00, 2'b00, 0, 16'h0000};
        tbl[18] = '{1, 2'b01, 1, 5'd18, 2'b01, 2'b00, 2'b00, 1, 16'hA5A5};
        tbl[19] = '{1, 2'b01, 1, 5'd19, 2'b01, 2'b00, 2'b00, 0, 16'hA5A5};
        tbl[20] = '{1, 2'b01, 0, 5'd20, 2'b01, 2'b00, 2'b00, 0, 16'hA5A5};
        tbl[21] = '{0, 2'b01, 0, 5'd21, 2'b00, 2'b00, 2'b00, 0, 16'h0000};
        tbl[22] = '{1, 2'b00, 1, 5'd22, 2'b00, 2'b00, 2'b00, 0, 16'h0000};
        tbl[23] = '{1, 2'b11, 0, 5'd23, 2'b01, 2'b00, 2'b00, 1, 16'hA5A5};
        tbl[24] = '{1, 2'b11, 0, 5'd24, 2'b01, 2'b00, 2'b00, 0, 16'hA5A5};
        tbl[25] = '{0, 2'b00, 0, 5'd25, 2'b00, 2'b00, 2'b00, 0, 16'h0000};

        for (int i = 0; i < 26; i++) begin
            rst_n              = tbl[i].rst_n;
            bus.i_req          = tbl[i].req;
            bus.i_eng_done     = tbl[i].eng_done;
            bus.i_eng_mat_addr = tbl[i].addr;
            bus.i_eng_vec_addr = tbl[i].addr[3:0];
            step();
            exp_vec = (tbl[i].gnt == 2'b01) ? 16'h2222 : (tbl[i].gnt == 2'b10) ? 16'h1111 : 16'h0000;
            chk($sformatf("row%0d gnt", i), 32'(bus.o_gnt), 32'(tbl[i].gnt));
            chk($sformatf("row%0d done", i), 32'(bus.o_done), 32'(tbl[i].done));
            chk($sformatf("row%0d err", i), 32'(bus.o_err), 32'(tbl[i].err));
            chk($sformatf("row%0d start", i), 32'(bus.o_eng_start), 32'(tbl[i].start));
            chk($sformatf("row%0d eng_mat", i), 32'(bus.o_eng_mat), 32'(tbl[i].mat));
            chk($sformatf("row%0d eng_vec", i), 32'(bus.o_eng_vec), 32'(exp_vec));
            chk($sformatf("row%0d mat_addr", i), 32'(bus.o_mat_addr), 32'(tbl[i].addr));
            chk($sformatf("row%0d vec_addr", i), 32'(bus.o_vec_addr), 32'(tbl[i].addr[3:0]));
        end

        // Timeout with no done: err in the 17th cycle after the start cycle.
        bus.i_eng_done = 1'b0;
        rst_n          = 1'b1;
        bus.i_req      = 2'b01;
        step();
        chk("to start", 32'(bus.o_eng_start), 32'd1);
        for (int c = 2; c <= 17; c++) begin
            step();
            chk($sformatf("to cyc%0d err", c), 32'(bus.o_err), 32'd0);
        end
        step();
        chk("to err pulse", 32'(bus.o_err), 32'h1);
        chk("to no done", 32'(bus.o_done), 32'h0);
        chk("to gnt held", 32'(bus.o_gnt), 32'h1);
        step();
        chk("to err one cycle", 32'(bus.o_err), 32'h0);
        bus.i_req = 2'b00;
        step();
        chk("to release", 32'(bus.o_gnt), 32'h0);

        // Done coincides with the final timeout cycle: done wins.
        bus.i_req = 2'b01;
        step();
        chk("co start", 32'(bus.o_eng_start), 32'd1);
        for (int c = 2; c <= 17; c++) step();
        chk("co still run", 32'(bus.o_done | bus.o_err), 32'h0);
        bus.i_eng_done = 1'b1;
        step();
        bus.i_eng_done = 1'b0;
        chk("co done", 32'(bus.o_done), 32'h1);
        chk("co no err", 32'(bus.o_err), 32'h0);
        bus.i_req = 2'b00;
        step();
        chk("co release", 32'(bus.o_gnt), 32'h0);
        chk("co done one cycle", 32'(bus.o_done), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
